// File: rtl/stopwatch_bcd.sv
// -----------------------------------------------------------------------------
// stopwatch_bcd
//   Four-digit BCD stopwatch (000.0 .. 999.9 s) with start/stop and clear
//   pushbuttons. The buttons are synchronised and debounced. A three-state FSM
//   (CLR / RUN / PAUSE) gates a prescaler that produces one count tick every
//   CLK_HZ/TICK_HZ cycles.
//
//   Optional feature, enabled by defining the macro STOPWATCH_LAP_EN:
//   a lap button that freezes the displayed value while the count keeps running.
//
// Parameters
//   CLK_HZ        input clock frequency in Hz
//   TICK_HZ       count rate in Hz (one count = one tenth of a second)
//   DEBOUNCE_CYC  cycles a synchronised button level must stay stable to be accepted
//
// Ports
//   clock    in   single clock; all state changes on its rising edge
//   rstn     in   asynchronous active-low reset
//   startPB  in   start/stop pushbutton, active high, asynchronous
//   clearPB  in   clear pushbutton, active high, asynchronous
//   lapPB    in   lap pushbutton, active high (used only with STOPWATCH_LAP_EN)
//   value    out  BCD digits: [15:12] hundreds of s ... [3:0] tenths of s
//   running  out  high while the FSM is in RUN
//   ovf      out  sticky flag, set when the count wraps 9999 -> 0000
// -----------------------------------------------------------------------------
module stopwatch_bcd #(
  parameter int CLK_HZ       = 5000000,
  parameter int TICK_HZ      = 10,
  parameter int DEBOUNCE_CYC = 50000
) (
  input  logic        clock,
  input  logic        rstn,
  input  logic        startPB,
  input  logic        clearPB,
  input  logic        lapPB,
  output logic [15:0] value,
  output logic        running,
  output logic        ovf
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DW  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYC - 1);

  // Button index: 0 = start, 1 = clear, 2 = lap (only present with the lap feature).
`ifdef STOPWATCH_LAP_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif

  typedef enum logic [1:0] {
    S_CLR   = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  logic [NB-1:0] w_raw;
  logic [NB-1:0] r_sync1;
  logic [NB-1:0] r_sync2;
  logic [NB-1:0] r_db;
  logic [NB-1:0] r_press;
  logic [DW-1:0] r_db_cnt [NB];

  state_t        r_state;
  state_t        w_state_next;
  logic          w_start;
  logic          w_clear;
  logic          w_enter_clr;
  logic          w_tick;
  logic [PW-1:0] r_presc;
  logic [15:0]   r_count;
  logic [15:0]   w_count_inc;
  logic          w_wrap;
  logic          r_ovf;

`ifdef STOPWATCH_LAP_EN
  assign w_raw = {lapPB, clearPB, startPB};
`else
  assign w_raw = {clearPB, startPB};
  // The lap button has no function in this build.
  logic w_unused_lap;
  assign w_unused_lap = lapPB;
`endif

  // ---------------------------------------------------------------------------
  // Synchroniser + debouncer + press-pulse generator, one lane per button.
  // A lane counts consecutive synchronised samples that differ from the
  // accepted level; the DEBOUNCE_CYC-th such sample flips the accepted level.
  // A press pulse is raised only on the accepted 0->1 flip, so holding a
  // button never repeats.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_press <= '0;
      // NOTE: the counter array is a set of control flops, not a storage RAM,
      // so each element is reset explicitly.
      for (int i = 0; i < NB; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < NB; i++) begin
        r_press[i] <= 1'b0;
        if (r_sync2[i] == r_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_db_cnt[i] <= '0;
          r_db[i]     <= r_sync2[i];
          r_press[i]  <= r_sync2[i];
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_start = r_press[0];
  assign w_clear = r_press[1];

  // ---------------------------------------------------------------------------
  // FSM: state register / next-state logic / output logic
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) r_state <= S_CLR;
    else       r_state <= w_state_next;
  end

  // NOTE: the next state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_CLR:   if (w_start) w_state_next = S_RUN;
      S_RUN:   if (w_start) w_state_next = S_PAUSE;  // clear is ignored while running
      S_PAUSE: begin
        // Clear has priority over a simultaneous start.
        if (w_clear)      w_state_next = S_CLR;
        else if (w_start) w_state_next = S_RUN;
      end
      default: w_state_next = S_CLR;
    endcase
  end

  always_comb begin
    running = (r_state == S_RUN);
  end

  // CLR is only reachable from PAUSE via a clear press.
  assign w_enter_clr = (r_state == S_PAUSE) && w_clear;

  // ---------------------------------------------------------------------------
  // Prescaler: advances in RUN, holds its partial count in PAUSE, zero in CLR.
  // ---------------------------------------------------------------------------
  assign w_tick = (r_state == S_RUN) && (r_presc == PRESC_LAST);

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_presc <= '0;
    end else if (r_state == S_RUN) begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
    end else if (r_state == S_CLR) begin
      r_presc <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // BCD increment: ripple the carry through the four digits in one cycle.
  // A digit at 9 (or any illegal value above it) rolls to 0 and carries.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic carry;
    carry       = 1'b1;
    w_count_inc = r_count;
    for (int d = 0; d < 4; d++) begin
      if (carry) begin
        if (r_count[4*d +: 4] >= 4'd9) begin
          w_count_inc[4*d +: 4] = 4'd0;
        end else begin
          w_count_inc[4*d +: 4] = r_count[4*d +: 4] + 4'd1;
          carry                 = 1'b0;
        end
      end
    end
    w_wrap = carry;  // all four digits rolled over: 9999 -> 0000
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (w_enter_clr) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (w_tick) begin
      r_count <= w_count_inc;
      if (w_wrap) r_ovf <= 1'b1;
    end
  end

  assign ovf = r_ovf;

  // ---------------------------------------------------------------------------
  // Lap hold (optional): a lap press in RUN toggles the hold; setting it
  // captures the live count. The hold survives PAUSE and is dropped on clear.
  // ---------------------------------------------------------------------------
`ifdef STOPWATCH_LAP_EN
  logic        r_hold;
  logic [15:0] r_lap;

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_hold <= 1'b0;
      r_lap  <= '0;
    end else if (w_enter_clr) begin
      r_hold <= 1'b0;
      r_lap  <= '0;
    end else if (r_press[2] && (r_state == S_RUN)) begin
      r_hold <= ~r_hold;
      if (!r_hold) r_lap <= r_count;
    end
  end

  assign value = r_hold ? r_lap : r_count;
`else
  assign value = r_count;
`endif

endmodule

// File: doc/stopwatch_bcd.md
STOPWATCH_BCD -- requirements
Module: stopwatch_bcd

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 5000000, meaning input clock frequency in Hz.
REQ-002 The block SHALL have parameter TICK_HZ, default 10, meaning count rate in Hz (one count = 0.1 s).
REQ-003 The block SHALL have parameter DEBOUNCE_CYC, default 50000, meaning the number of clock cycles a synchronised button level must stay stable before it is accepted (10 ms).
REQ-004 Port clock, input, 1 bit: the single clock (5 MHz clk5 domain); all state SHALL change only on its rising edge or on reset.
REQ-005 Port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port startPB, input, 1 bit: start/stop pushbutton, active high, asynchronous to clock.
REQ-007 Port clearPB, input, 1 bit: clear pushbutton, active high, asynchronous to clock.
REQ-008 Port lapPB, input, 1 bit: lap pushbutton, active high; used only when STOPWATCH_LAP_EN is defined.
REQ-009 Port value, output, 16 bits: four BCD digits, [15:12] hundreds of seconds down to [3:0] tenths; drives the display interface value input directly.
REQ-010 Port running, output, 1 bit: high in state RUN.
REQ-011 Port ovf, output, 1 bit: sticky flag, high once the count has wrapped.

Function
REQ-012 Each button SHALL pass through a 2-flop synchroniser, then a debouncer that accepts a new level only after DEBOUNCE_CYC consecutive equal samples.
REQ-013 Each accepted 0->1 transition SHALL produce exactly one single-cycle press pulse; holding the button SHALL NOT produce repeat pulses.
REQ-014 The FSM SHALL have three states: CLR, RUN and PAUSE.
REQ-015 CLR SHALL go to RUN on a start press.
REQ-016 RUN SHALL go to PAUSE on a start press.
REQ-017 PAUSE SHALL go to RUN on a start press, and to CLR on a clear press.
REQ-018 A clear press in RUN SHALL be ignored.
REQ-019 If start and clear presses occur in the same cycle in PAUSE, clear SHALL win and start SHALL be discarded.
REQ-020 The prescaler SHALL count 0..(CLK_HZ/TICK_HZ - 1) only in RUN and emit a one-cycle tick on the wrap to 0.
REQ-021 The prescaler SHALL hold its value in PAUSE, so a resume keeps the partial tick.
REQ-022 The prescaler SHALL be held at 0 in CLR.
REQ-023 On each tick, the tenths digit SHALL increment.
REQ-024 A digit going from 9 SHALL become 0 and carry into the next digit in the same cycle; no digit SHALL ever hold a value above 9.
REQ-025 A tick at 9999 SHALL give 0000 in the same cycle and set ovf; counting SHALL continue.
REQ-026 value SHALL be registered and SHALL update on the clock edge after the tick (one-cycle latency).
REQ-027 Entering CLR SHALL zero the count and clear ovf in the same cycle.
REQ-028 The latency from a button input changing to the FSM state change SHALL be 2 + DEBOUNCE_CYC + 1 cycles, plus or minus 1.

Reset
REQ-029 Asserting rstn low SHALL asynchronously force: state CLR, prescaler 0, count 0000, value 16'h0000, running 0, ovf 0.
REQ-030 Asserting rstn low SHALL also force all synchronisers and debouncers to 0, the lap hold released and the held copy 0.
REQ-031 A reset asserted mid-count SHALL abort the count with no residual press pulse after release.
REQ-032 The reset release SHALL take effect on the next rising clock edge.

Configuration
REQ-033 With macro STOPWATCH_LAP_EN defined, a lap press in RUN SHALL toggle a hold flag.
REQ-034 While the hold flag is set, value SHALL show the count captured at the lap press and the internal count SHALL continue.
REQ-035 The hold flag SHALL survive RUN->PAUSE and SHALL be released by a clear or a second lap press.
REQ-036 With STOPWATCH_LAP_EN defined, lap presses in PAUSE or CLR SHALL be ignored.
REQ-037 Without STOPWATCH_LAP_EN, lapPB SHALL be unused, value SHALL always equal the live count, and no hold logic SHALL be synthesised.

Verification
REQ-038 Bench settings SHALL be CLK_HZ=100, TICK_HZ=10, DEBOUNCE_CYC=4.
REQ-039 Scenario: reset, then a start press, run 25 ticks -> value=16'h0025, running=1, ovf=0.
REQ-040 Scenario: start press, 7 ticks, start press, wait 50 ticks, start press, 3 ticks -> value=16'h0010 with no count during the pause.
REQ-041 Scenario: count preloaded by running to 16'h9998, then 2 ticks -> value=16'h0000 and ovf=1; a pause then clear -> value 0, ovf 0.
REQ-042 Scenario: clear press in RUN -> no change; start and clear pressed in the same cycle in PAUSE -> state CLR, value 0.
REQ-043 Scenario: glitch on startPB shorter than DEBOUNCE_CYC -> no state change; startPB held 1000 cycles -> exactly one transition.
REQ-044 Scenario (STOPWATCH_LAP_EN): lap at 16'h0012, run 5 more ticks -> value=16'h0012; lap again -> value=16'h0017; rstn pulse mid-run -> all outputs 0 at once.
